// File: rtl/uart_pkg.sv
// Shared UART definitions: frame line levels, default sizes and the frame state
// encoding. Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_CNT_W      = 14;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam logic START_BIT       = 1'b0;
  localparam logic STOP_BIT        = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..max and pulses tick on the last clock of each bit.
// A held clear parks the counter at zero so a frame always starts on a full bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CNT_W = UART_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] max,
  output logic             tick
);

  logic [CNT_W-1:0] count;

  assign tick = (count == max);

  always_ff @(posedge clk) begin
    if (reset || clear || tick) count <= '0;
    else                        count <= count + 1'b1;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default, byte accepted on a valid/ready handshake.
// Define UART_TX_PARITY_EN to add a parity bit (parity_odd selects odd parity).
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int CNT_W     = UART_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_W-1:0]     baud_tick_max,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
`ifdef UART_TX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_e          state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic [CNT_W-1:0]     max_q;
  logic                 tick;
  logic                 fire;
  logic                 tx_n;
`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`endif

  assign fire = tx_valid && tx_ready;

  uart_baud_gen #(.CNT_W(CNT_W)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE),
    .max   (max_q),
    .tick  (tick)
  );

  // tx is registered from the next-state value so the line changes on the same
  // edge as the state and never passes through combinational logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_idx <= '0;
      tx      <= UART_IDLE_LEVEL;
    end else begin
      state   <= state_n;
      bit_idx <= bit_idx_n;
      tx      <= tx_n;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_n;
    if (fire) begin
      max_q <= baud_tick_max;
`ifdef UART_TX_PARITY_EN
      par_q <= (^tx_data) ^ parity_odd;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_idx_n = bit_idx;
    case (state)
      IDLE: begin
        if (fire) begin
          state_n   = START;
          shift_n   = tx_data;
          bit_idx_n = '0;
        end
      end
      START: if (tick) state_n = DATA;
      DATA: begin
        if (tick) begin
          shift_n = shift >> 1;
          if (bit_idx == LAST_IDX) begin
            bit_idx_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n   = PARITY;
`else
            state_n   = STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_n = STOP;
`endif
      STOP: if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (state == IDLE) && !reset;
    busy     = (state != IDLE);
    tx_done  = (state == STOP) && tick;
    case (state_n)
      START:   tx_n = START_BIT;
      DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = par_q;
`endif
      STOP:    tx_n = STOP_BIT;
      default: tx_n = UART_IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table of literal frames, hand-written corner sequences and
// random frames against a bit-list model with a mid-bit sampling decoder.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_valid = 1'b0;
  logic        parity_odd = 1'b0;
  logic [13:0] baud_tick_max = '0;
  logic [7:0]  tx_data = '0;
  logic        tx_ready, tx, busy, tx_done;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [63:0] cap_tx, cap_done, cap_busy, cap_ready, exp_w;
  int exp_len;

  typedef struct {
    logic [7:0] data;
    int         max;
    logic       odd;
    string      bits;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .CNT_W(14)) dut (
    .clk           (clk),
    .reset         (reset),
    .baud_tick_max (baud_tick_max),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
`ifdef UART_TX_PARITY_EN
    .parity_odd    (parity_odd),
`endif
    .tx_ready      (tx_ready),
    .tx            (tx),
    .busy          (busy),
    .tx_done       (tx_done)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic exp_clear();
    exp_w = '0;
    exp_len = 0;
  endtask

  task automatic push_bit(input logic b, input int max);
    for (int r = 0; r <= max; r++) begin
      if (exp_len < 64) exp_w[exp_len] = b;
      exp_len++;
    end
  endtask

  // Reference frame: start, data LSB first, optional parity, stop; each bit max+1 clocks.
  task automatic model_frame(input logic [7:0] d, input int max, input logic odd);
    push_bit(1'b0, max);
    for (int i = 0; i < 8; i++) push_bit(d[i], max);
`ifdef UART_TX_PARITY_EN
    push_bit((^d) ^ odd, max);
`endif
    push_bit(1'b1, max);
  endtask

  task automatic string_frame(input string s, input int max);
    for (int k = 0; k < s.len(); k++) push_bit(s[k] == "1", max);
  endtask

  // Receiver-style recovery: sample each data bit in the middle of its period.
  function automatic logic [7:0] decode(input logic [63:0] w, input int base, input int max);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[base + (i + 1) * (max + 1) + max / 2];
    return r;
  endfunction

  task automatic start_frame(input logic [7:0] d, input int max, input logic odd,
                             input logic [7:0] after_d, input logic hold);
    int n;
    tx_data = d;
    baud_tick_max = 14'(max);
    parity_odd = odd;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) check("handshake_timeout", {63'd0, tx_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    tx_data = after_d;
    tx_valid = hold;
    if (!hold) begin
      baud_tick_max = '1;
      parity_odd = ~odd;
    end
  endtask

  task automatic capture(input int len, input int pulse_at, input logic [7:0] pulse_data,
                         input int drop_valid_at, input int reset_at);
    cap_tx = '0; cap_done = '0; cap_busy = '0; cap_ready = '0;
    for (int i = 0; i < len; i++) begin
      cap_tx[i] = tx;
      cap_done[i] = tx_done;
      cap_busy[i] = busy;
      cap_ready[i] = tx_ready;
      if (pulse_at >= 0 && i == pulse_at) begin tx_valid = 1'b1; tx_data = pulse_data; end
      if (pulse_at >= 0 && i == pulse_at + 1) tx_valid = 1'b0;
      if (drop_valid_at >= 0 && i == drop_valid_at) tx_valid = 1'b0;
      if (reset_at >= 0 && i == reset_at) reset = 1'b1;
      if (reset_at >= 0 && i == reset_at + 1) reset = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input int max, input logic odd);
    start_frame(d, max, odd, ~d, 1'b0);
    capture(exp_len, -1, 8'h00, -1, -1);
    check({tag, "_wave"}, cap_tx, exp_w);
    check({tag, "_done"}, cap_done, 64'd1 << (exp_len - 1));
    check({tag, "_busy"}, cap_busy, (64'd1 << exp_len) - 1);
    check({tag, "_loopback"}, {56'd0, decode(cap_tx, 0, max)}, {56'd0, d});
    check({tag, "_ready_after"}, {62'd0, tx_ready, tx}, 64'd3);
  endtask

  initial begin
    logic [7:0] d;
    int         m;
    logic       o;
    int         base2;

`ifdef UART_TX_PARITY_EN
    vecs.push_back('{8'hA5, 3, 1'b0, "01010010101"});
    vecs.push_back('{8'h81, 0, 1'b0, "01000000101"});
    vecs.push_back('{8'h07, 1, 1'b0, "01110000011"});
    vecs.push_back('{8'h07, 1, 1'b1, "01110000001"});
`else
    vecs.push_back('{8'hA5, 3, 1'b0, "0101001011"});
    vecs.push_back('{8'h81, 0, 1'b0, "0100000011"});
    vecs.push_back('{8'h00, 1, 1'b0, "0000000001"});
    vecs.push_back('{8'hFF, 1, 1'b0, "0111111111"});
    vecs.push_back('{8'h3C, 2, 1'b0, "0001111001"});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {60'd0, tx, busy, tx_done, tx_ready}, 64'b1000);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {62'd0, tx_ready, tx}, 64'd3);

    // Literal frames from the table
    foreach (vecs[v]) begin
      exp_clear();
      string_frame(vecs[v].bits, vecs[v].max);
      run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].max, vecs[v].odd);
    end

    // Back-to-back with tx_valid held: 0x00 then 0xFF, one idle clock between
    exp_clear();
    model_frame(8'h00, 1, 1'b0);
    push_bit(1'b1, 0);
    model_frame(8'hFF, 1, 1'b0);
    base2 = NB * 2 + 1;
    start_frame(8'h00, 1, 1'b0, 8'hFF, 1'b1);
    capture(exp_len, -1, 8'h00, base2, -1);
    check("b2b_wave", cap_tx, exp_w);
    check("b2b_done", cap_done, (64'd1 << (NB * 2 - 1)) | (64'd1 << (exp_len - 1)));
    check("b2b_idle_ready", {63'd0, cap_ready[NB * 2]}, 64'd1);
    check("b2b_loop0", {56'd0, decode(cap_tx, 0, 1)}, 64'h00);
    check("b2b_loop1", {56'd0, decode(cap_tx, base2, 1)}, 64'hFF);

    // Mid-frame valid pulse and data change are ignored
    exp_clear();
    model_frame(8'h5A, 2, 1'b0);
    start_frame(8'h5A, 2, 1'b0, 8'h0F, 1'b0);
    capture(exp_len, 10, 8'hC3, -1, -1);
    check("pulse_wave", cap_tx, exp_w);
    check("pulse_loopback", {56'd0, decode(cap_tx, 0, 2)}, 64'h5A);
    repeat (6) @(negedge clk);
    check("pulse_no_new_frame", {62'd0, busy, tx}, 64'd1);

    // Reset during DATA bit 3 (clocks 16..19 of a max=3 frame)
    exp_clear();
    model_frame(8'hA5, 3, 1'b0);
    start_frame(8'hA5, 3, 1'b0, 8'h5A, 1'b0);
    capture(45, -1, 8'h00, -1, 17);
    check("rst_bit3_before", {63'd0, cap_tx[17]}, {63'd0, exp_w[17]});
    check("rst_tx_high", {63'd0, cap_tx[18]}, 64'd1);
    check("rst_busy_low", {63'd0, cap_busy[18]}, 64'd0);
    check("rst_no_done", cap_done, 64'd0);
    check("rst_ready_after", {63'd0, cap_ready[19]}, 64'd1);
    check("rst_line_idle", (cap_tx >> 18) & ((64'd1 << 27) - 1), (64'd1 << 27) - 1);

    // Random frames against the model
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      m = $urandom_range(0, 3);
      o = 1'($urandom_range(0, 1));
      exp_clear();
      model_frame(d, m, o);
      run_frame($sformatf("rand%0d", k), d, m, o);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
